mem_port_arbiter: RTL

//   Shares one memory port between the instruction-fetch requester (I) and the

---
 rtl/mem_port_arbiter_pkg.sv | 25 ++
 rtl/mem_arb_pick.sv | 35 +++
 rtl/mem_port_arbiter.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the memory-port arbiter: FSM states, owner encoding,
// transaction payload layout and the common 32-bit width type.
package mem_port_arbiter_pkg;

    typedef logic [31:0] u32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } arb_state_t;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } arb_owner_t;

    typedef struct packed {
        logic       we;
        u32         addr;
        u32         wdata;
        logic [3:0] strb;
    } arb_payload_t;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational winner select between the fetch (I) and load/store (D)
// requesters. Define ARB_ROUND_ROBIN_EN to alternate on contention (grant the
// requester that did not own the previous transaction); otherwise D always
// wins over I.
module mem_arb_pick
    import mem_port_arbiter_pkg::*;
(
    input  logic       i_req,
    input  logic       d_req,
    input  arb_owner_t last_owner,
    output logic       grant,
    output arb_owner_t owner
);

`ifndef ARB_ROUND_ROBIN_EN
    logic unused_last_owner;
    assign unused_last_owner = last_owner;
`endif

    // Pick the winner; only contention depends on the arbitration policy
    always_comb begin
        grant = i_req | d_req;
        owner = OWN_D;
        if (!d_req) begin
            owner = OWN_I;
        end else if (i_req) begin
`ifdef ARB_ROUND_ROBIN_EN
            owner = (last_owner == OWN_D) ? OWN_I : OWN_D;
`else
            owner = OWN_D;
`endif
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch (I) and load/store (D).
// One transaction in flight: IDLE -> BUSY -> RESP -> IDLE. Payload and owner
// are latched at grant; the response is a one-cycle pulse to the owner.
// TIMEOUT != 0 ends a transaction with an error response if memory never acks.
// Optional macro ARB_ROUND_ROBIN_EN selects alternating arbitration (see
// mem_arb_pick); undefined gives fixed D-over-I priority.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_req,
    input  logic [ADDR_W-1:0]     i_addr,
    output logic                  i_resp_valid,
    output logic                  i_resp_err,
    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [ADDR_W-1:0]     d_addr,
    input  logic [DATA_W-1:0]     d_wdata,
    input  logic [DATA_W/8-1:0]   d_strb,
    output logic                  d_resp_valid,
    output logic                  d_resp_err,
    output logic [DATA_W-1:0]     resp_rdata,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    output logic [DATA_W/8-1:0]   mem_strb,
    input  logic                  mem_ack,
    input  logic [DATA_W-1:0]     mem_rdata
);

    localparam int STRB_W = DATA_W / 8;

    arb_state_t          state_q, state_d;
    arb_owner_t          owner_q, owner_d;
    arb_owner_t          last_q, last_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [STRB_W-1:0]   strb_q, strb_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                err_q, err_d;
    u32                  cnt_q, cnt_d;

    logic                pick_grant;
    arb_owner_t          pick_owner;
    logic                busy, resp;

    mem_arb_pick u_pick (
        .i_req      (i_req),
        .d_req      (d_req),
        .last_owner (last_q),
        .grant      (pick_grant),
        .owner      (pick_owner)
    );

    // State, latched transaction and response registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            owner_q <= OWN_I;
            last_q  <= OWN_I;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            strb_q  <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            strb_q  <= strb_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state: grant in IDLE, wait for ack or timeout in BUSY, one RESP cycle
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        strb_d  = strb_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (pick_grant) begin
                    state_d = BUSY;
                    owner_d = pick_owner;
                    last_d  = pick_owner;
                    cnt_d   = '0;
                    if (pick_owner == OWN_D) begin
                        we_d    = d_we;
                        addr_d  = d_addr;
                        wdata_d = d_wdata;
                        strb_d  = d_strb;
                    end else begin
                        // Fetches are always reads with no byte enables
                        we_d    = 1'b0;
                        addr_d  = i_addr;
                        wdata_d = '0;
                        strb_d  = '0;
                    end
                end
            end
            BUSY: begin
                // An ack in the same cycle the limit is reached still wins
                if (mem_ack) begin
                    state_d = RESP;
                    rdata_d = mem_rdata;
                    err_d   = 1'b0;
                end else if ((TIMEOUT != 0) && (cnt_q + 32'd1 == u32'(TIMEOUT))) begin
                    state_d = RESP;
                    rdata_d = '0;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy = (state_q == BUSY);
    assign resp = (state_q == RESP);

    assign mem_req   = busy;
    assign mem_we    = busy & we_q;
    assign mem_addr  = busy ? addr_q  : '0;
    assign mem_wdata = busy ? wdata_q : '0;
    assign mem_strb  = busy ? strb_q  : '0;

    assign i_resp_valid = resp & (owner_q == OWN_I);
    assign d_resp_valid = resp & (owner_q == OWN_D);
    assign i_resp_err   = i_resp_valid & err_q;
    assign d_resp_err   = d_resp_valid & err_q;
    assign resp_rdata   = resp ? rdata_q : '0;

endmodule
